// File: rtl/fetch_pc_ir_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_ir_unit
//
// Program counter, instruction register and memory-address multiplexer stage
// that sits in front of the control unit. It applies the control unit's
// PC-write, PC-mux, IR-load and address-mux decisions, and presents the IR
// as the instruction to decode.
//
// PC and IR together form one scan chain:
//   scan_in -> PC[MSB] ... PC[0] -> IR[MSB] ... IR[0] -> scan_out
// scan_out can be daisy-chained into the control unit's state register.
//
// Ports:
//   clk                        clock, all state updates on the rising edge
//   rst                        synchronous active-high reset (PC=0, IR=0)
//   processor_enable           functional update enable
//   PC_write_enable            load PC with the selected next-PC value
//   PC_mux_select[1:0]         00 PC+1, 01 ACC, 10 PC-3, 11 PC+2
//   IR_load_enable             load IR from mem_data_in
//   Memory_address_mux_select  00 IR[PC_WIDTH-1:0], 01 ACC, 10/11 PC
//   ACC                        accumulator value
//   mem_data_in                memory read data (combinational read)
//   mem_addr                   memory address (combinational)
//   instruction                IR contents
//   PC_out                     PC zero-extended to DATA_WIDTH
//   scan_enable                scan shift enable
//   scan_in                    scan chain input
//   scan_out                   scan chain output (IR[0])
// -----------------------------------------------------------------------------
module fetch_pc_ir_unit #(
  parameter int PC_WIDTH   = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  processor_enable,
  input  logic                  PC_write_enable,
  input  logic [1:0]            PC_mux_select,
  input  logic                  IR_load_enable,
  input  logic [1:0]            Memory_address_mux_select,
  input  logic [DATA_WIDTH-1:0] ACC,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] PC_out,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out
);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] ir_d;
  logic [PC_WIDTH-1:0]   pc_next_s;

  // Only the low PC_WIDTH bits of ACC address memory or load the PC.
  logic unused_acc_hi_s;
  assign unused_acc_hi_s = &{1'b0, ACC[DATA_WIDTH-1:PC_WIDTH]};

  // Next-PC candidate; arithmetic wraps modulo 2^PC_WIDTH naturally.
  always_comb begin
    pc_next_s = pc_q;
    case (PC_mux_select)
      2'b00:   pc_next_s = pc_q + PC_WIDTH'(1);
      2'b01:   pc_next_s = ACC[PC_WIDTH-1:0];
      2'b10:   pc_next_s = pc_q - PC_WIDTH'(3);
      2'b11:   pc_next_s = pc_q + PC_WIDTH'(2);
      default: pc_next_s = pc_q;
    endcase
  end

  // Register next-state: scan shift beats functional update; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (scan_enable) begin
      pc_d = {scan_in, pc_q[PC_WIDTH-1:1]};
      ir_d = {pc_q[0], ir_q[DATA_WIDTH-1:1]};
    end else if (processor_enable) begin
      // IR samples mem_data_in driven from the pre-edge address, so a FETCH
      // captures the instruction at the old PC while the PC advances.
      if (PC_write_enable) begin
        pc_d = pc_next_s;
      end else begin
        pc_d = pc_q;
      end
      if (IR_load_enable) begin
        ir_d = mem_data_in;
      end else begin
        ir_d = ir_q;
      end
    end else begin
      pc_d = pc_q;
      ir_d = ir_q;
    end
  end

  // PC / IR state registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= {PC_WIDTH{1'b0}};
      ir_q <= {DATA_WIDTH{1'b0}};
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  // Memory address mux; purely combinational and not gated by the enable.
  always_comb begin
    mem_addr = pc_q;
    case (Memory_address_mux_select)
      2'b00:   mem_addr = ir_q[PC_WIDTH-1:0];
      2'b01:   mem_addr = ACC[PC_WIDTH-1:0];
      2'b10:   mem_addr = pc_q;
      2'b11:   mem_addr = pc_q;
      default: mem_addr = pc_q;
    endcase
  end

  assign instruction = ir_q;
  assign PC_out      = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, pc_q};
  assign scan_out    = ir_q[0];

endmodule

// File: tb/tb_fetch_pc_ir_unit.sv
module tb_fetch_pc_ir_unit;

  logic       clk;
  logic       rst;
  logic       processor_enable;
  logic       PC_write_enable;
  logic [1:0] PC_mux_select;
  logic       IR_load_enable;
  logic [1:0] Memory_address_mux_select;
  logic [7:0] ACC;
  logic [7:0] mem_data_in;
  logic [4:0] mem_addr;
  logic [7:0] instruction;
  logic [7:0] PC_out;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

  fetch_pc_ir_unit #(.PC_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .processor_enable          (processor_enable),
    .PC_write_enable           (PC_write_enable),
    .PC_mux_select             (PC_mux_select),
    .IR_load_enable            (IR_load_enable),
    .Memory_address_mux_select (Memory_address_mux_select),
    .ACC                       (ACC),
    .mem_data_in               (mem_data_in),
    .mem_addr                  (mem_addr),
    .instruction               (instruction),
    .PC_out                    (PC_out),
    .scan_enable               (scan_enable),
    .scan_in                   (scan_in),
    .scan_out                  (scan_out)
  );

  // Combinational-read memory model
  assign mem_data_in = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       se;
    logic       si;
    logic       pe;
    logic       pcwe;
    logic [1:0] sel;
    logic       irle;
    logic [1:0] asel;
    logic [7:0] acc;
    logic [4:0] exp_pre;   // mem_addr before the edge
    logic [4:0] exp_pc;    // PC after the edge
    logic [7:0] exp_ir;    // IR after the edge
    logic [4:0] exp_addr;  // mem_addr after the edge, same selects
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic bit_in, input logic rst_v);
    rst = rst_v;
    scan_enable = 1'b1;
    scan_in = bit_in;
    processor_enable = 1'b1;
    PC_write_enable = 1'b1;
    IR_load_enable = 1'b1;
    PC_mux_select = 2'b00;
    Memory_address_mux_select = 2'b10;
    tick();
  endtask

  logic [12:0] pat;
  logic [12:0] old_chain;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0]  = 8'hE3;
    mem[12] = 8'h9A;
    mem[23] = 8'h2C;

    rst = 1'b0; scan_enable = 1'b0; scan_in = 1'b0; processor_enable = 1'b0;
    PC_write_enable = 1'b0; PC_mux_select = 2'b00; IR_load_enable = 1'b0;
    Memory_address_mux_select = 2'b00; ACC = 8'h00;

    //            rst  se   si   pe   pcwe sel    irle asel   acc     pre    pc     ir     addr
    // reset wins over scan_enable
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,2'b00,1'b1,2'b01,8'h00, 5'd0,  5'd0,  8'h00, 5'd0};
    // FETCH: IR gets mem[0], PC advances
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,1'b1,2'b10,8'h00, 5'd0,  5'd1,  8'hE3, 5'd1};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,2'b10,8'h1F, 5'd1,  5'd31, 8'hE3, 5'd31};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b10,8'h00, 5'd31, 5'd0,  8'hE3, 5'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,2'b10,8'h1E, 5'd0,  5'd30, 8'hE3, 5'd30};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b11,1'b0,2'b10,8'h00, 5'd30, 5'd0,  8'hE3, 5'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,2'b10,8'h01, 5'd0,  5'd1,  8'hE3, 5'd1};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b10,1'b0,2'b10,8'h00, 5'd1,  5'd30, 8'hE3, 5'd30};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,2'b10,8'h04, 5'd30, 5'd4,  8'hE3, 5'd4};
    // PC_we=0 holds PC
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b10,8'h00, 5'd4,  5'd4,  8'hE3, 5'd4};
    // JMP via ACC=0xF7 -> 23
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b01,1'b0,2'b10,8'hF7, 5'd4,  5'd23, 8'hE3, 5'd23};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b01,8'hF7, 5'd23, 5'd23, 8'hE3, 5'd23};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b01,8'h25, 5'd5,  5'd23, 8'hE3, 5'd5};
    // IR load from mem[23]=0x2C
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b1,2'b10,8'h00, 5'd23, 5'd23, 8'h2C, 5'd23};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,8'h00, 5'd12, 5'd23, 8'h2C, 5'd12};
    // processor_enable=0: hold, address mux still live
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b00,8'h00, 5'd12, 5'd23, 8'h2C, 5'd12};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b10,8'h00, 5'd23, 5'd23, 8'h2C, 5'd23};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b01,8'h05, 5'd5,  5'd23, 8'h2C, 5'd5};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b11,8'h00, 5'd23, 5'd23, 8'h2C, 5'd23};
    vecs[19] = '{1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,2'b00,8'h00, 5'd12, 5'd23, 8'h2C, 5'd12};
    // fetch through IR address: IR gets mem[12], new addr = 0x9A[4:0]
    vecs[20] = '{1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,1'b1,2'b00,8'h00, 5'd12, 5'd24, 8'h9A, 5'd26};

    tick();

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst;
      scan_enable = vecs[i].se;
      scan_in = vecs[i].si;
      processor_enable = vecs[i].pe;
      PC_write_enable = vecs[i].pcwe;
      PC_mux_select = vecs[i].sel;
      IR_load_enable = vecs[i].irle;
      Memory_address_mux_select = vecs[i].asel;
      ACC = vecs[i].acc;
      #1;
      if (i > 0) chk($sformatf("v%0d pre_addr", i), mem_addr, vecs[i].exp_pre);
      tick();
      chk($sformatf("v%0d pc_out", i), PC_out, {3'b000, vecs[i].exp_pc});
      chk($sformatf("v%0d instruction", i), instruction, vecs[i].exp_ir);
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d scan_out", i), scan_out, vecs[i].exp_ir[0]);
    end

    // Scan in 1,0,1,1,0,0,1,1,1,1,0,1,0 while enables pulse; old contents
    // (IR=0x9A then PC=24) come out IR[0] first.
    pat = 13'b0_1011_1100_1101;   // pat[k] = k-th bit shifted in
    old_chain = {5'd24, 8'h9A};
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("scan_old_bit%0d", k), scan_out, old_chain[k]);
      shift(pat[k], 1'b0);
    end
    // first bit lands in IR[0], last in PC[4]: PC=01011, IR=11001101
    chk("scan_load_pc", PC_out, 8'h0B);
    chk("scan_load_ir", instruction, 8'hCD);

    for (int k = 0; k < 13; k++) begin
      chk($sformatf("scan_out_bit%0d", k), scan_out, pat[k]);
      shift(1'b0, 1'b0);
    end
    chk("scan_flush_pc", PC_out, 8'h00);
    chk("scan_flush_ir", instruction, 8'h00);

    // Reset on shift cycle 6 from a non-zero chain
    for (int k = 0; k < 5; k++) shift(1'b1, 1'b0);
    chk("midscan_pre_pc", PC_out, 8'h1F);
    shift(1'b1, 1'b1);
    chk("midscan_rst_pc", PC_out, 8'h00);
    chk("midscan_rst_ir", instruction, 8'h00);
    chk("midscan_rst_so", scan_out, 1'b0);
    shift(1'b1, 1'b0);
    chk("midscan_resume_pc", PC_out, 8'h10);
    chk("midscan_resume_ir", instruction, 8'h00);
    for (int k = 0; k < 5; k++) shift(1'b1, 1'b0);
    chk("midscan_final_pc", PC_out, 8'h1F);
    chk("midscan_final_ir", instruction, 8'h80);

    scan_enable = 1'b0;
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
